a2d_conv_sched: RTL and testbench
=================================

// Module: a2d_conv_sched
// PURPOSE
//  Schedules the shared SPI A2D among four channels in a fixed round: left load cell, right load cell,
//  steer pot and battery. Rounds start periodically. Holds the latest 12-bit result per channel.
//  Feeds lft_ld/rght_ld to the steer-enable logic and steer_pot/batt to balance/safety logic.
//  Sits between the SPI master (wrt/done/cmd/rd_data) and the consumers.
// PARAMETERS
//  CONV_PERIOD  4096  clocks between round-start ticks (>=64); chip-level sets 1048576 for silicon
//  PER_W        20    width of period counter (must hold CONV_PERIOD-1)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous, active-low reset
//  en         in   1   high = periodic rounds enabled; low = timer held at 0, no new round starts
//  wrt        out  1   1-clk pulse: start SPI transaction
//  cmd        out  16  SPI command word {2'b00, ch[2:0], 11'h000}
//  done       in   1   1-clk pulse from SPI master: transaction complete
//  rd_data    in   16  SPI read data, valid when done=1; only [11:0] used
//  lft_ld     out  12  latest ch0 result
//  rght_ld    out  12  latest ch4 result
//  steer_pot  out  12  latest ch5 result
//  batt       out  12  latest ch6 result
//  rnd_vld    out  1   1-clk pulse, cycle after the batt register updates (round complete)
//  ovr        out  1   sticky: a tick arrived while a tick was already pending; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, channel index 0, period counter 0, pending flag 0.
//  Timer: counts 0..CONV_PERIOD-1 and wraps while en=1. tick = (cnt==CONV_PERIOD-1) && en.
//   en=0 clears cnt synchronously.
//  Pending: tick sets pend. Leaving IDLE clears pend. tick while pend=1 sets ovr (ticks merge).
//  Channel order/index: idx 0..3 -> ch 0,4,5,6. cmd driven from idx and stable through both
//   transactions.
//  FSM states:
//   IDLE: pend -> CMD (same clk as pend seen); done ignored.
//   CMD: wrt=1 for one clk -> WT1.
//   WT1: wait done (indefinitely); on done -> GAP (data discarded: A2D returns prior conversion).
//   GAP: exactly one idle clk -> RD.
//   RD: wrt=1 one clk, same cmd -> WT2.
//   WT2: on done, capture rd_data[11:0] into reg for idx (visible next clk).
//    If idx==3: idx<=0, go to DONE. Else idx++, go to CMD.
//   DONE: rnd_vld=1 one clk -> IDLE (-> CMD next clk if pend).
//  Latency: per channel = 2 SPI transactions + 3 clks of FSM overhead (CMD, GAP, RD issue).
//  Boundaries:
//   en falling mid-round: round completes; no new round.
//   tick on same clk as DONE: pend set, next round begins 2 clks after rnd_vld.
//   done while wrt asserted: ignored.
//   reset mid-transaction: FSM to IDLE immediately; in-flight SPI result never captured.
//  Registers unaffected for channels not yet reached in an aborted round (reset clears all anyway).
// CONFIGURATION
//  LD_FILT_EN defined: lft_ld/rght_ld update as (old + new)>>1 using a 13-bit sum, truncated
//   (2-tap IIR smoothing of load cells). steer_pot/batt unfiltered.
//   First round after reset still averages with 0.
//  LD_FILT_EN undefined: all four registers load rd_data[11:0] directly.
// TESTING
//  1 Reset, en=1, SPI model returns 12'h100,200,300,400 (per ch) -> after first tick cmd sequence
//    16'h0000 x2, 16'h2000 x2, 16'h2800 x2, 16'h3000 x2; lft_ld=12'h100, batt=12'h400, one rnd_vld.
//  2 Discard check: first-of-pair returns 12'hFFF, second 12'h123 -> lft_ld=12'h123, never 12'hFFF.
//  3 CONV_PERIOD=64, SPI done delayed 40 clks -> second tick during round sets ovr=1;
//    rounds back-to-back; ovr stays 1.
//  4 en dropped during ch5 transaction -> round finishes (rnd_vld pulses), no wrt afterwards, cnt=0.
//  5 rst_n asserted in WT2 of ch4 -> all outputs 0 asynchronously; late done ignored; rght_ld stays 0.
//  6 LD_FILT_EN defined, lft sample 12'h200 two rounds -> lft_ld=12'h100 then 12'h180;
//    undefined -> 12'h200 both.

Source files
------------

// File: rtl/a2d_conv_sched.sv
// Round-robin scheduler for the shared SPI A2D: converts ch 0,4,5,6 each period and holds results.
// Optional LD_FILT_EN: 2-tap averaging on the two load-cell channels.
module a2d_conv_sched #(
  parameter int unsigned CONV_PERIOD = 4096,
  parameter int unsigned PER_W       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        rnd_vld,
  output logic        ovr
);

  localparam int unsigned DW = 12;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 2;
  localparam logic [PER_W-1:0] CNT_LAST = PER_W'(CONV_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WT1, S_GAP, S_RD, S_WT2, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q, pend_d;
  logic            ovr_q, ovr_d;
  logic            wrt_q, wrt_d;
  logic            rnd_vld_q, rnd_vld_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic [DW-1:0]   lft_q, lft_d, rght_q, rght_d, steer_q, steer_d, batt_q, batt_d;
  logic            tick;
  logic [DW-1:0]   lft_new, rght_new;
  logic            unused_bits;

  // Round slot to physical A2D channel number
  function automatic logic [2:0] ch_of(input logic [IW-1:0] i);
    case (i)
      2'd0:    ch_of = 3'd0;
      2'd1:    ch_of = 3'd4;
      2'd2:    ch_of = 3'd5;
      default: ch_of = 3'd6;
    endcase
  endfunction

`ifdef LD_FILT_EN
  logic [DW:0] lft_sum, rght_sum;
  assign lft_sum     = {1'b0, lft_q} + {1'b0, rd_data[DW-1:0]};
  assign rght_sum    = {1'b0, rght_q} + {1'b0, rd_data[DW-1:0]};
  assign lft_new     = lft_sum[DW:1];
  assign rght_new    = rght_sum[DW:1];
  assign unused_bits = ^{rd_data[CW-1:DW], lft_sum[0], rght_sum[0]};
`else
  assign lft_new     = rd_data[DW-1:0];
  assign rght_new    = rd_data[DW-1:0];
  assign unused_bits = ^rd_data[CW-1:DW];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    wrt_d     = 1'b0;
    rnd_vld_d = 1'b0;
    lft_d     = lft_q;
    rght_d    = rght_q;
    steer_d   = steer_q;
    batt_d    = batt_q;

    tick = en && (cnt_q == CNT_LAST);
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + PER_W'(1);

    case (state_q)
      S_IDLE: if (pend_q) begin
        state_d = S_CMD;
        wrt_d   = 1'b1;
        pend_d  = 1'b0;
      end
      S_CMD:  state_d = S_WT1;
      // First reply of the pair carries the previous conversion; drop it
      S_WT1:  if (done) state_d = S_GAP;
      S_GAP: begin
        state_d = S_RD;
        wrt_d   = 1'b1;
      end
      S_RD:   state_d = S_WT2;
      S_WT2: if (done) begin
        case (idx_q)
          2'd0:    lft_d   = lft_new;
          2'd1:    rght_d  = rght_new;
          2'd2:    steer_d = rd_data[DW-1:0];
          default: batt_d  = rd_data[DW-1:0];
        endcase
        if (idx_q == IW'(3)) begin
          idx_d     = '0;
          state_d   = S_DONE;
          rnd_vld_d = 1'b1;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_CMD;
          wrt_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ticks merge into one pending request; a second one is flagged
    if (tick) begin
      pend_d = 1'b1;
      if (pend_q) ovr_d = 1'b1;
    end

    cmd_d = {2'b00, ch_of(idx_d), 11'h000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wrt_q     <= 1'b0;
      rnd_vld_q <= 1'b0;
      cmd_q     <= '0;
      lft_q     <= '0;
      rght_q    <= '0;
      steer_q   <= '0;
      batt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      wrt_q     <= wrt_d;
      rnd_vld_q <= rnd_vld_d;
      cmd_q     <= cmd_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      steer_q   <= steer_d;
      batt_q    <= batt_d;
    end
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign rnd_vld   = rnd_vld_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Directed bench for a2d_conv_sched with a small SPI responder model (short period for sim time).
module tb_a2d_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        rnd_vld, ovr;

  int n_checks = 0;
  int n_errors = 0;

  // SPI model state
  logic [11:0] first_val [8];
  logic [11:0] sec_val   [8];
  int          spi_dly = 0;
  int          dly_cnt = 0;
  bit          busy = 1'b0;
  bit          pair = 1'b0;
  bit          cur_pair = 1'b0;
  logic [2:0]  cur_ch = 3'd0;
  int          wrt_cnt = 0;
  int          rnd_cnt = 0;
  bit          saw_fff = 1'b0;
  logic [15:0] cmd_log [$];

  a2d_conv_sched #(.CONV_PERIOD(64), .PER_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot),
    .batt(batt), .rnd_vld(rnd_vld), .ovr(ovr)
  );

  always #5 clk = ~clk;

  // SPI responder: answers each wrt with done after spi_dly+1 clocks
  always @(negedge clk) begin
    done = 1'b0;
    if (!rst_n) pair = 1'b0;
    if (busy) begin
      if (dly_cnt == 0) begin
        done    = 1'b1;
        rd_data = {4'hA, (cur_pair ? sec_val[cur_ch] : first_val[cur_ch])};
        busy    = 1'b0;
      end else begin
        dly_cnt = dly_cnt - 1;
      end
    end
    if (rst_n && wrt) begin
      busy     = 1'b1;
      dly_cnt  = spi_dly;
      cur_ch   = cmd[13:11];
      cur_pair = pair;
      pair     = ~pair;
      wrt_cnt  = wrt_cnt + 1;
      cmd_log.push_back(cmd);
    end
    if (rnd_vld) rnd_cnt = rnd_cnt + 1;
    if (lft_ld == 12'hFFF) saw_fff = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rnd(input string tag, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(posedge clk);
      #1;
      if (rnd_vld) got = 1'b1;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic wait_wrt_cmd(input string tag, input logic [15:0] c, input int nth, input int max_cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < max_cyc && seen < nth; i++) begin
      @(posedge clk);
      #1;
      if (wrt && cmd == c) seen++;
    end
    chk(tag, 32'(seen), 32'(nth));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(60);
  endtask

  task automatic set_vals();
    first_val[0] = 12'h100; sec_val[0] = 12'h100;
    first_val[4] = 12'h200; sec_val[4] = 12'h200;
    first_val[5] = 12'h300; sec_val[5] = 12'h300;
    first_val[6] = 12'h400; sec_val[6] = 12'h400;
  endtask

  initial begin
    int wc;
    logic [15:0] exp_cmd [8];
    exp_cmd = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
                16'h2800, 16'h2800, 16'h3000, 16'h3000};
    for (int i = 0; i < 8; i++) begin
      first_val[i] = 12'h000;
      sec_val[i]   = 12'h000;
    end
    set_vals();
    rd_data = 16'h0;
    done    = 1'b0;
    en      = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_lft", 32'(lft_ld), 32'd0);
    chk("rst_rght", 32'(rght_ld), 32'd0);
    chk("rst_steer", 32'(steer_pot), 32'd0);
    chk("rst_batt", 32'(batt), 32'd0);
    chk("rst_rnd_vld", 32'(rnd_vld), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: first full round, command sequence and results
    cmd_log.delete();
    @(negedge clk);
    en = 1'b1;
    wait_rnd("t1_rnd_timeout", 300);
    chk("t1_cmd_count", 32'(cmd_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < cmd_log.size(); i++)
      chk($sformatf("t1_cmd%0d", i), 32'(cmd_log[i]), 32'(exp_cmd[i]));
`ifdef LD_FILT_EN
    chk("t1_lft", 32'(lft_ld), 32'h080);
    chk("t1_rght", 32'(rght_ld), 32'h100);
`else
    chk("t1_lft", 32'(lft_ld), 32'h100);
    chk("t1_rght", 32'(rght_ld), 32'h200);
`endif
    chk("t1_steer", 32'(steer_pot), 32'h300);
    chk("t1_batt", 32'(batt), 32'h400);
    cyc(1);
    chk("t1_rnd_pulse_width", 32'(rnd_vld), 32'd0);
    chk("t1_rnd_count", 32'(rnd_cnt), 32'd1);
    chk("t1_ovr", 32'(ovr), 32'd0);

    // Test 2: first reply of each pair must be discarded
    saw_fff      = 1'b0;
    first_val[0] = 12'hFFF;
    sec_val[0]   = 12'h123;
    wait_rnd("t2_rnd_timeout", 120);
`ifdef LD_FILT_EN
    chk("t2_lft", 32'(lft_ld), 32'h0D1);
`else
    chk("t2_lft", 32'(lft_ld), 32'h123);
`endif
    chk("t2_never_fff", 32'(saw_fff), 32'd0);

    // Test 3: slow SPI, ticks pile up, rounds run back to back
    spi_dly = 40;
    wait_rnd("t3_rnd1_timeout", 1500);
    wait_rnd("t3_rnd2_timeout", 1500);
    chk("t3_ovr_set", 32'(ovr), 32'd1);
    cyc(1);
    chk("t3_idle_gap_wrt", 32'(wrt), 32'd0);
    cyc(1);
    chk("t3_back_to_back_wrt", 32'(wrt), 32'd1);
    chk("t3_restart_cmd", 32'(cmd), 32'h0000);
    wait_rnd("t3_rnd3_timeout", 1500);
    chk("t3_ovr_sticky", 32'(ovr), 32'd1);

    // Test 4: en drops during ch5 transaction; round finishes, nothing follows
    spi_dly = 5;
    set_vals();
    do_reset();
    chk("t4_ovr_cleared", 32'(ovr), 32'd0);
    @(negedge clk);
    en = 1'b1;
    wait_wrt_cmd("t4_ch5_timeout", 16'h2800, 1, 400);
    @(negedge clk);
    en = 1'b0;
    wait_rnd("t4_rnd_timeout", 200);
    chk("t4_steer", 32'(steer_pot), 32'h300);
    wc = wrt_cnt;
    cyc(150);
    chk("t4_no_wrt_after", 32'(wrt_cnt - wc), 32'd0);
    chk("t4_cnt_zero", 32'(dut.cnt_q), 32'd0);

    // Test 5: async reset in WT2 of ch4; late done must be ignored
    spi_dly = 10;
    do_reset();
    @(negedge clk);
    en = 1'b1;
    wait_wrt_cmd("t5_ch4_rd_timeout", 16'h2000, 2, 400);
    cyc(3);
`ifdef LD_FILT_EN
    chk("t5_lft_before", 32'(lft_ld), 32'h080);
`else
    chk("t5_lft_before", 32'(lft_ld), 32'h100);
`endif
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("t5_async_lft", 32'(lft_ld), 32'd0);
    chk("t5_async_cmd", 32'(cmd), 32'd0);
    chk("t5_async_wrt", 32'(wrt), 32'd0);
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    wc = wrt_cnt;
    cyc(30);
    chk("t5_rght_zero", 32'(rght_ld), 32'd0);
    chk("t5_lft_zero", 32'(lft_ld), 32'd0);
    chk("t5_no_wrt", 32'(wrt_cnt - wc), 32'd0);
    chk("t5_no_rnd", 32'(rnd_vld), 32'd0);

    // Test 6: load-cell filtering across two rounds after reset
    spi_dly = 0;
    first_val[0] = 12'h200;
    sec_val[0]   = 12'h200;
    do_reset();
    @(negedge clk);
    en = 1'b1;
    wait_rnd("t6_rnd1_timeout", 300);
`ifdef LD_FILT_EN
    chk("t6_lft_r1", 32'(lft_ld), 32'h100);
`else
    chk("t6_lft_r1", 32'(lft_ld), 32'h200);
`endif
    wait_rnd("t6_rnd2_timeout", 200);
`ifdef LD_FILT_EN
    chk("t6_lft_r2", 32'(lft_ld), 32'h180);
`else
    chk("t6_lft_r2", 32'(lft_ld), 32'h200);
`endif
    chk("t6_batt_unfiltered", 32'(batt), 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
